// File: rtl/audio_pkg.sv
// audio_pkg: shared audio state encoding and default sample width.
package audio_pkg;
    localparam int SAMPLE_W_DEF = 16;
    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} i2s_state_t;
endpackage

// File: rtl/i2s_codec_if_if.sv
// i2s_codec_if_if: host-side bus of the I2S codec block.
//   tx_data/tx_valid/tx_ready : mono playback sample handshake (host -> codec block)
//   rx_left/rx_right/rx_valid : last complete captured frame plus one-cycle strobe
interface i2s_codec_if_if #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W_DEF
);
    logic [SAMPLE_W-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [SAMPLE_W-1:0] rx_left;
    logic [SAMPLE_W-1:0] rx_right;
    logic                rx_valid;
    modport master (output tx_data, tx_valid, input tx_ready, rx_left, rx_right, rx_valid);
    modport slave (input tx_data, tx_valid, output tx_ready, rx_left, rx_right, rx_valid);
endinterface

// File: rtl/i2s_chan_shift.sv
// i2s_chan_shift: bit counter plus SIPO/PISO for one I2S channel slot.
//   i_clr       : LR edge; restarts the counter and loads i_load_word into the PISO
//   i_act       : channel active; enables shifting for the first SAMPLE_W bits
//   i_sdi       : serial ADC bit
//   o_last      : this edge shifts in the final bit; o_word is the complete word
//   o_short     : fewer than SAMPLE_W bits would be held if the channel ended now
//   o_sdo       : current DAC bit, 0 once the word is exhausted
module i2s_chan_shift #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W_DEF,
    localparam int CW = $clog2(SAMPLE_W + 1)
) (
    input  logic                i_bclk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    input  logic                i_act,
    input  logic                i_sdi,
    input  logic [SAMPLE_W-1:0] i_load_word,
    output logic                o_last,
    output logic                o_short,
    output logic [SAMPLE_W-1:0] o_word,
    output logic                o_sdo
);
    localparam logic [CW-1:0] FULL = CW'(SAMPLE_W);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_W - 1);
    logic [CW-1:0]       cnt;
    logic [SAMPLE_W-2:0] sipo;
    logic [SAMPLE_W-1:0] piso;
    logic                shift;
    // The edge that ends a channel may still carry that channel's last bit (one-bit delay).
    assign shift   = i_act && cnt < FULL;
    assign o_last  = shift && cnt == LAST;
    assign o_short = cnt < LAST;
    assign o_word  = {sipo, i_sdi};
    assign o_sdo   = piso[SAMPLE_W-1] && cnt < FULL;
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            sipo <= '0;
            piso <= '0;
        end else begin
            cnt  <= i_clr ? '0 : cnt + CW'(shift);
            sipo <= shift ? o_word[SAMPLE_W-2:0] : sipo;
            piso <= i_clr ? i_load_word : shift ? piso << 1 : piso;
        end
    end
endmodule

// File: rtl/i2s_codec_if.sv
// i2s_codec_if: I2S slave codec interface (shared LRCK, capture + playback).
//   i_bclk, i_rst_n         : codec bit clock, async active-low reset
//   i_en, i_loopback        : block enable, DAC replays last captured frame
//   i_lrck, i_adcdat        : codec LR clock (0 = left) and ADC serial data
//   o_dacdat                : DAC serial data, retimed on falling i_bclk
//   o_underrun, o_frame_err : one-cycle status pulses
//   bus                     : tx sample handshake and captured frame outputs
module i2s_codec_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic          i_bclk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_loopback,
    input  logic          i_lrck,
    input  logic          i_adcdat,
    output logic          o_dacdat,
    output logic          o_underrun,
    output logic          o_frame_err,
    i2s_codec_if_if.slave bus
);
    i2s_state_t          state;
    logic                lrck_q, buf_full, left_ok, pend, rx_valid;
    logic [SAMPLE_W-1:0] buf_data, tx_r, left_hold, right_hold, rx_left, rx_right;
    logic [SAMPLE_W-1:0] mono, load_word, word;
    logic                lr_edge, fall, rise, run, xfer, err, last, short_ch, sdo;
    assign lr_edge = i_lrck != lrck_q;
    assign fall    = i_en && lr_edge && !i_lrck;
    assign rise    = lr_edge && i_lrck;
    assign run     = i_en && state != S_IDLE;
    assign xfer    = bus.tx_valid && !buf_full;
    assign err     = run && lr_edge && short_ch;
    // A sample handed over on the falling LR edge itself bypasses the buffer.
    assign mono      = buf_full ? buf_data : xfer ? bus.tx_data : '0;
    assign load_word = fall ? (i_loopback ? rx_left : mono) : tx_r;
    assign bus.tx_ready = !buf_full;
    assign bus.rx_left  = rx_left;
    assign bus.rx_right = rx_right;
    assign bus.rx_valid = rx_valid;
    i2s_chan_shift #(.SAMPLE_W(SAMPLE_W)) u_shift (
        .i_bclk      (i_bclk),
        .i_rst_n     (i_rst_n),
        .i_clr       (lr_edge),
        .i_act       (run),
        .i_sdi       (i_adcdat),
        .i_load_word (load_word),
        .o_last      (last),
        .o_short     (short_ch),
        .o_word      (word),
        .o_sdo       (sdo)
    );
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            lrck_q      <= 1'b0;
            buf_full    <= 1'b0;
            buf_data    <= '0;
            tx_r        <= '0;
            left_hold   <= '0;
            right_hold  <= '0;
            left_ok     <= 1'b0;
            pend        <= 1'b0;
            rx_left     <= '0;
            rx_right    <= '0;
            rx_valid    <= 1'b0;
            o_underrun  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            lrck_q      <= i_lrck;
            state       <= !i_en ? S_IDLE : fall ? S_LEFT : (rise && state == S_LEFT) ? S_RIGHT : state;
            buf_full    <= i_en && ((fall && !i_loopback) ? 1'b0 : buf_full || xfer);
            buf_data    <= xfer ? bus.tx_data : buf_data;
            tx_r        <= fall ? (i_loopback ? rx_right : mono) : tx_r;
            o_underrun  <= fall && !i_loopback && !buf_full && !xfer;
            o_frame_err <= err;
            // A frame is only published if its left channel completed without error.
            left_ok     <= run && !fall && !err && (left_ok || (last && state == S_LEFT));
            left_hold   <= (last && state == S_LEFT) ? word : left_hold;
            right_hold  <= (last && state == S_RIGHT) ? word : right_hold;
            pend        <= last && state == S_RIGHT && left_ok;
            rx_left     <= pend ? left_hold : rx_left;
            rx_right    <= pend ? right_hold : rx_right;
            rx_valid    <= pend;
        end
    end
    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) o_dacdat <= 1'b0;
        else o_dacdat <= state != S_IDLE && sdo;
    end
endmodule

// File: tb/tb_i2s_codec_if.sv
// tb_i2s_codec_if: table-driven frame vectors plus hand-written error/reset sequences.
module tb_i2s_codec_if;
    logic bclk = 1'b0, rst_n = 1'b1, en = 1'b1, lb = 1'b0, lrck = 1'b1, adc = 1'b0;
    logic dac, urun, ferr;
    int   n_vec = 0, n_bad = 0;
    logic [15:0] dac_l, dac_r;
    int   rxv_n, rxv_e, urun_n, ferr_n, dac_stray;

    i2s_codec_if_if bus ();

    i2s_codec_if dut (
        .i_bclk      (bclk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_loopback  (lb),
        .i_lrck      (lrck),
        .i_adcdat    (adc),
        .o_dacdat    (dac),
        .o_underrun  (urun),
        .o_frame_err (ferr),
        .bus         (bus)
    );

    always #5 bclk = ~bclk;

    typedef struct {
        logic [15:0] adc_l, adc_r;
        logic        tx_ok;
        logic [15:0] tx_w;
        logic        lb;
        logic [15:0] dac_l, dac_r;
        logic        urun;
        logic        ready;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic clear_obs();
        dac_l = '0; dac_r = '0; rxv_n = 0; rxv_e = -1; urun_n = 0; ferr_n = 0; dac_stray = 0;
    endtask

    // e = edge index within the frame; edge 0 is the falling LR edge
    task automatic observe(input int e);
        if (e >= 1 && e <= 16) dac_l[16-e] = dac;
        else if (e >= 33 && e <= 48) dac_r[48-e] = dac;
        else if (dac !== 1'b0) dac_stray++;
        if (bus.rx_valid === 1'b1) begin
            rxv_n++;
            rxv_e = e;
        end
        if (urun === 1'b1) urun_n++;
        if (ferr === 1'b1) ferr_n++;
    endtask

    task automatic offer(input logic [15:0] w);
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        tick();
        bus.tx_valid = 1'b0;
        chk("tx_accepted_ready_low", 32'(bus.tx_ready), 32'd0);
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int len);
        clear_obs();
        for (int e = 0; e < len; e++) begin
            lrck = (e >= 32);
            adc  = (e >= 1 && e <= 16) ? l[16-e] : (e >= 33 && e <= 48) ? r[48-e] : 1'b0;
            tick();
            observe(e);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_dacdat"}, 32'(dac), 32'd0);
        chk({tag, "_rx_left"}, 32'(bus.rx_left), 32'd0);
        chk({tag, "_rx_right"}, 32'(bus.rx_right), 32'd0);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
        chk({tag, "_underrun"}, 32'(urun), 32'd0);
        chk({tag, "_frame_err"}, 32'(ferr), 32'd0);
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        tbl[0] = '{16'hA5C3, 16'h1234, 1'b1, 16'h8001, 1'b0, 16'h8001, 16'h8001, 1'b0, 1'b1};
        tbl[1] = '{16'h00FF, 16'hFF00, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[2] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h0000, 1'b1, 16'h00FF, 16'hFF00, 1'b0, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 16'h7FFE, 16'h7FFE, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1};
        tbl[5] = '{16'h4321, 16'h8765, 1'b1, 16'h1234, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{16'h0001, 16'h8000, 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b1};

        #2 rst_n = 1'b0;
        #1 chk_reset_values("por");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        for (int i = 0; i < 7; i++) begin
            lb = tbl[i].lb;
            if (tbl[i].tx_ok) offer(tbl[i].tx_w);
            frame(tbl[i].adc_l, tbl[i].adc_r, 64);
            chk($sformatf("v%0d_rx_valid_count", i), 32'(rxv_n), 32'd1);
            chk($sformatf("v%0d_rx_valid_edge", i), 32'(rxv_e), 32'd49);
            chk($sformatf("v%0d_rx_left", i), 32'(bus.rx_left), 32'(tbl[i].adc_l));
            chk($sformatf("v%0d_rx_right", i), 32'(bus.rx_right), 32'(tbl[i].adc_r));
            chk($sformatf("v%0d_dac_left", i), 32'(dac_l), 32'(tbl[i].dac_l));
            chk($sformatf("v%0d_dac_right", i), 32'(dac_r), 32'(tbl[i].dac_r));
            chk($sformatf("v%0d_dac_idle_bits", i), 32'(dac_stray), 32'd0);
            chk($sformatf("v%0d_underrun_pulses", i), 32'(urun_n), 32'(tbl[i].urun));
            chk($sformatf("v%0d_frame_err_pulses", i), 32'(ferr_n), 32'd0);
            chk($sformatf("v%0d_tx_ready", i), 32'(bus.tx_ready), 32'(tbl[i].ready));
        end
        lb = 1'b0;

        // right channel cut short after 10 bits
        frame(16'h1111, 16'h2222, 43);
        chk("short_rx_valid_count", 32'(rxv_n), 32'd0);
        chk("short_frame_err_early", 32'(ferr_n), 32'd0);
        chk("short_rx_left_held", 32'(bus.rx_left), 32'h0001);
        frame(16'hC0DE, 16'hBEEF, 64);
        chk("after_short_frame_err", 32'(ferr_n), 32'd1);
        chk("after_short_rx_valid_count", 32'(rxv_n), 32'd1);
        chk("after_short_rx_left", 32'(bus.rx_left), 32'hC0DE);
        chk("after_short_rx_right", 32'(bus.rx_right), 32'hBEEF);

        // reset in the middle of the left channel
        offer(16'hFFFF);
        clear_obs();
        for (int e = 0; e < 8; e++) begin
            lrck = 1'b0;
            adc  = 1'b1;
            tick();
        end
        chk("pre_reset_dacdat", 32'(dac), 32'd1);
        chk("pre_reset_rx_left", 32'(bus.rx_left), 32'hC0DE);
        rst_n = 1'b0;
        #1 chk_reset_values("midframe_rst");
        tick();
        tick();
        rst_n = 1'b1;
        clear_obs();
        for (int e = 0; e < 42; e++) begin
            lrck = (e >= 10);
            tick();
            observe(100);
        end
        chk("post_rst_idle_rx_valid", 32'(rxv_n), 32'd0);
        chk("post_rst_idle_dacdat", 32'(dac_stray), 32'd0);
        chk("post_rst_idle_underrun", 32'(urun_n), 32'd0);
        frame(16'h1357, 16'h2468, 64);
        chk("resume_rx_valid_count", 32'(rxv_n), 32'd1);
        chk("resume_rx_left", 32'(bus.rx_left), 32'h1357);
        chk("resume_rx_right", 32'(bus.rx_right), 32'h2468);
        chk("resume_underrun", 32'(urun_n), 32'd1);
        chk("resume_dac_left", 32'(dac_l), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
